stb_sampler: RTL
================

Name: stb_sampler

Overview:
- Downstream consumer of the strobe generator in the measure unit.
- Once the generator reports ready, counts strobe rising edges and samples a comparator at each one.
- Accumulates a hit count over a programmed number of strobes; a strobe watchdog guards the run.
- Results are handed to the CSR/SoC side with a done/ack handshake; one run yields one point of a threshold or delay sweep.

Parameters:
- CNT_WIDTH, 16: width of n_samples_i, hits_o, samples_o.
- TO_WIDTH, 32: width of the watchdog counter and timeout_i.
- SYNC_STAGES, 2: synchronizer depth applied identically to stb_i and cmp_i.

Ports:
- clk_i  in  1  single clock.
- arst_i  in  1  reset; synchronous, active-low.
- start_i  in  1  single-cycle run request; honoured only in IDLE.
- n_samples_i  in  CNT_WIDTH  strobes to sample; latched on start.
- timeout_i  in  TO_WIDTH  max cycles between strobe edges; 0 disables the watchdog; latched on start.
- stb_i  in  1  strobe from the generator (asynchronous-safe).
- stb_rdy_i  in  1  generator ready flag.
- cmp_i  in  1  comparator output (asynchronous).
- ack_i  in  1  consumer acknowledge of the result.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  result valid.
- hits_o  out  CNT_WIDTH  strobes at which the comparator was 1.
- samples_o  out  CNT_WIDTH  strobes actually sampled.
- timeout_o  out  1  run ended by the watchdog.

Behaviour:
- Reset: arst_i low at a clock edge forces IDLE. All outputs and counters are cleared: busy_o=0, done_o=0, hits_o=0, samples_o=0, timeout_o=0. Reset mid-run discards the partial result; no done is emitted.
- Input path: stb_i and cmp_i each pass through a SYNC_STAGES sync_ff.
- Edge detect: stb_edge = stb_s & ~stb_s_d1. The comparator is sampled as cmp_s in the same cycle stb_edge is high.
- IDLE: on start_i, latch n_samples_i and timeout_i, clear the counters and timeout_o, then go to WAIT_RDY. If n_samples_i==0, go directly to DONE with zero counts.
- WAIT_RDY: wait for stb_rdy_i==1, then go to ARM. The watchdog is inactive here.
- ARM: the first stb_edge is discarded because it may be a partial strobe; then go to SAMPLE. The watchdog runs in this state.
- SAMPLE: on each stb_edge, samples += 1 and hits += cmp_s. When samples reaches n_samples in that cycle, go to DONE the next cycle.
- Watchdog (ARM/SAMPLE):
  - The counter clears on every stb_edge and increments otherwise.
  - If timeout != 0 and the counter equals timeout, set timeout_o=1 and go to DONE with the partial counts.
  - If the edge and the expiry occur in the same cycle, the edge wins: the edge is counted and the counter clears.
- DONE: done_o=1, one cycle after the terminating event. hits_o, samples_o and timeout_o stay stable while done_o=1. The cycle ack_i is sampled high, done_o drops next cycle and the FSM returns to IDLE.
- Results persist after ack until the next start.
- ack_i outside DONE is ignored. start_i outside IDLE is ignored. start_i in the same cycle as ack_i is ignored (IDLE is entered after the ack).
- stb_rdy_i falling during ARM/SAMPLE: no effect; the watchdog covers a stalled generator.
- Counters: hits never exceeds samples. samples never exceeds n_samples. No wrap is possible.
- Latency: stb_i pin to counted edge is SYNC_STAGES+1 cycles; the counted edge appears in samples_o the following cycle.

Optional Feature:
- Macro STB_SAMPLER_CMP_MAJORITY_EN.
- Defined:
  - cmp_s is replaced by a 2-of-3 majority over its last three synchronized values.
  - stb_edge is delayed by one extra register so that the vote window is centred on the edge.
  - Total pin-to-count latency is SYNC_STAGES+2.
- Undefined: raw cmp_s is used as described in Behaviour.

Decomposition:
- Package measure_pkg holds:
  - enum stb_sampler_state {IDLE, WAIT_RDY, ARM, SAMPLE, DONE}, one-hot 5 bits, matching the generator's one-hot style;
  - localparams for default CNT_WIDTH and TO_WIDTH.
- Sub-module stb_edge_det: sync_ff plus the registered rising-edge detector, reused for stb_i. cmp_i uses a bare sync_ff.

Test Plan:
- n=8, timeout=1000, 50-cycle strobe period, cmp tied 1, stb_rdy high → first edge skipped; done_o with hits=8, samples=8, timeout_o=0.
- n=10, cmp toggled so it is 1 at every other strobe → hits=5, samples=10; results stable until ack_i; done_o drops one cycle after ack.
- n=6, timeout=200, strobe stopped after 3 counted edges → timeout_o=1, samples=3, done_o asserted 200 cycles after the last edge (±1 documented).
- n=0 start → done_o after one cycle, all counts 0; stb_rdy held low, n=4 → stays in WAIT_RDY with busy_o=1, and a strobe there is not counted.
- Reset asserted (arst_i=0 at a clock edge) mid-SAMPLE at samples=3 → next cycle IDLE, all outputs 0; a new start then completes normally.
- With STB_SAMPLER_CMP_MAJORITY_EN, a one-cycle cmp glitch coincident with each edge → hits=0; without the macro, the same stimulus gives hits=n.

Source files
------------

// File: rtl/measure_pkg.sv
// Shared definitions for the measure unit: sampler FSM encoding (one-hot, like
// the strobe generator), default counter widths and a small voting helper.
package measure_pkg;

  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_TO_WIDTH  = 32;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    WAIT_RDY = 5'b00010,
    ARM      = 5'b00100,
    SAMPLE   = 5'b01000,
    DONE     = 5'b10000
  } stb_sampler_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/stb_edge_det.sv
// Strobe input conditioning: synchronizer followed by a registered
// rising-edge detector; edge_o is high for one cycle per strobe.
module stb_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic stb_i,
  output logic edge_o
);

  logic stb_s;
  logic stb_s_d1_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (stb_i),
    .q_o    (stb_s)
  );

  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      stb_s_d1_q <= 1'b0;
    end else begin
      stb_s_d1_q <= stb_s;
    end
  end

  assign edge_o = stb_s & ~stb_s_d1_q;

endmodule

// File: rtl/sync_ff.sv
// Plain multi-stage synchronizer for an asynchronous single-bit input.
// Stages clear on the synchronous active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/stb_sampler.sv
// Strobe sampler: counts strobe edges after generator ready, samples the comparator
// on each, guards with a watchdog. Optional STB_SAMPLER_CMP_MAJORITY_EN: 2-of-3 cmp vote.
module stb_sampler
  import measure_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int TO_WIDTH    = DEF_TO_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_samples_i,
  input  logic [TO_WIDTH-1:0]  timeout_i,
  input  logic                 stb_i,
  input  logic                 stb_rdy_i,
  input  logic                 cmp_i,
  input  logic                 ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] hits_o,
  output logic [CNT_WIDTH-1:0] samples_o,
  output logic                 timeout_o
);

  logic cmp_s;
  logic stb_edge_raw;
  logic stb_edge;
  logic cmp_v;

  stb_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_stb_edge (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .stb_i  (stb_i),
    .edge_o (stb_edge_raw)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_cmp_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (cmp_i),
    .q_o    (cmp_s)
  );

`ifdef STB_SAMPLER_CMP_MAJORITY_EN
  // Edge delayed one cycle so the three-sample vote window is centred on it.
  logic [1:0] cmp_hist_q;
  logic       stb_edge_q;

  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      cmp_hist_q <= '0;
      stb_edge_q <= 1'b0;
    end else begin
      cmp_hist_q <= {cmp_hist_q[0], cmp_s};
      stb_edge_q <= stb_edge_raw;
    end
  end

  assign stb_edge = stb_edge_q;
  assign cmp_v    = maj3(cmp_s, cmp_hist_q[0], cmp_hist_q[1]);
`else
  assign stb_edge = stb_edge_raw;
  assign cmp_v    = cmp_s;
`endif

  stb_sampler_state_t   state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [TO_WIDTH-1:0]  to_q, to_d;
  logic [TO_WIDTH-1:0]  wd_q, wd_d;
  logic [CNT_WIDTH-1:0] hits_q, hits_d;
  logic [CNT_WIDTH-1:0] samples_q, samples_d;
  logic                 tout_q, tout_d;
  logic                 wd_expired;

  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      state_q   <= IDLE;
      n_q       <= '0;
      to_q      <= '0;
      wd_q      <= '0;
      hits_q    <= '0;
      samples_q <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      to_q      <= to_d;
      wd_q      <= wd_d;
      hits_q    <= hits_d;
      samples_q <= samples_d;
      tout_q    <= tout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    to_d       = to_q;
    wd_d       = wd_q;
    hits_d     = hits_q;
    samples_d  = samples_q;
    tout_d     = tout_q;
    wd_expired = (to_q != '0) && (wd_q == to_q);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d       = n_samples_i;
          to_d      = timeout_i;
          wd_d      = '0;
          hits_d    = '0;
          samples_d = '0;
          tout_d    = 1'b0;
          state_d   = (n_samples_i == '0) ? DONE : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        wd_d = '0;
        if (stb_rdy_i) state_d = ARM;
      end
      ARM: begin
        // First edge after ready may belong to a partial strobe: drop it.
        if (stb_edge) begin
          wd_d    = '0;
          state_d = SAMPLE;
        end else if (wd_expired) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + TO_WIDTH'(1);
        end
      end
      SAMPLE: begin
        // An edge in the expiry cycle takes priority over the watchdog.
        if (stb_edge) begin
          wd_d      = '0;
          samples_d = samples_q + CNT_WIDTH'(1);
          hits_d    = hits_q + CNT_WIDTH'(cmp_v);
          if (samples_d == n_q) state_d = DONE;
        end else if (wd_expired) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + TO_WIDTH'(1);
        end
      end
      DONE: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign hits_o    = hits_q;
  assign samples_o = samples_q;
  assign timeout_o = tout_q;

endmodule
